// File: rtl/bc_adjust.sv
// bc_adjust -- per-pixel brightness/contrast stage.
//
// Holds a committed signed brightness offset and an unsigned Q4.4 contrast
// gain. Adjust pulses only mark a step as pending. Pending steps are applied
// at the next frame boundary, so a frame never changes its settings partway
// through. Each 8-bit channel is mapped as
//   out = clamp(((p - 128) * gain >>> 4) + 128 + offset, 0, 255)
// through a fixed 3-stage pipeline.
//
// Ports:
//   clk            pixel clock, rising edge
//   rst            asynchronous active-high reset
//   en_bc_i        brightness/contrast enable; when low, pixels pass through
//                  and adjust pulses are ignored
//   frame_en_i     one-cycle frame-boundary strobe (commit point)
//   binc_i/bdec_i  brightness step up/down pulses
//   cinc_i/cdec_i  contrast step up/down pulses
//   pix_in_i       {R,G,B} input pixel
//   valid_in_i     pix_in_i qualifier
//   sync_in_i      {vs,hs,de} sideband
//   pix_out_o      adjusted pixel, 3 cycles after input
//   valid_out_o    valid_in_i delayed 3 cycles
//   sync_out_o     sync_in_i delayed 3 cycles
//   offset_out_o   committed offset, signed two's complement
//   gain_out_o     committed gain, Q4.4
module bc_adjust #(
  parameter int B_STEP  = 8,
  parameter int B_LIMIT = 128,
  parameter int G_RESET = 16,
  parameter int G_STEP  = 2,
  parameter int G_MIN   = 4,
  parameter int G_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_bc_i,
  input  logic        frame_en_i,
  input  logic        binc_i,
  input  logic        bdec_i,
  input  logic        cinc_i,
  input  logic        cdec_i,
  input  logic [23:0] pix_in_i,
  input  logic        valid_in_i,
  input  logic [2:0]  sync_in_i,
  output logic [23:0] pix_out_o,
  output logic        valid_out_o,
  output logic [2:0]  sync_out_o,
  output logic [8:0]  offset_out_o,
  output logic [7:0]  gain_out_o
);

  localparam logic signed [9:0] OFF_MAX  = 10'(B_LIMIT);
  localparam logic signed [9:0] OFF_MIN  = 10'(-B_LIMIT);
  localparam logic signed [9:0] OFF_STEP = 10'(B_STEP);
  localparam logic [8:0]        GAIN_HI  = 9'(G_MAX);
  localparam logic [8:0]        GAIN_LO  = 9'(G_MIN);
  localparam logic [8:0]        GAIN_STP = 9'(G_STEP);

  // ---------------------------------------------------------------------
  // Control: pending step flags and committed offset/gain
  // ---------------------------------------------------------------------
  logic [8:0] offset_q, offset_d;
  logic [7:0] gain_q, gain_d;
  logic       pend_bi_q, pend_bi_d;
  logic       pend_bd_q, pend_bd_d;
  logic       pend_ci_q, pend_ci_d;
  logic       pend_cd_q, pend_cd_d;

  // A pulse is dropped if its opposite arrives in the same cycle.
  logic capBi, capBd, capCi, capCd;
  assign capBi = en_bc_i & binc_i & ~bdec_i;
  assign capBd = en_bc_i & bdec_i & ~binc_i;
  assign capCi = en_bc_i & cinc_i & ~cdec_i;
  assign capCd = en_bc_i & cdec_i & ~cinc_i;

  logic signed [9:0] offWide, offUp, offDn;
  logic [8:0]        gainWide, gainUp, gainDn;

  always_comb begin
    offWide = $signed({offset_q[8], offset_q});
    offUp   = offWide + OFF_STEP;
    offDn   = offWide - OFF_STEP;
    gainWide = {1'b0, gain_q};
    gainUp   = gainWide + GAIN_STP;
    // Check against the floor before subtracting so gainDn never wraps.
    gainDn   = (gainWide < GAIN_LO + GAIN_STP) ? GAIN_LO : gainWide - GAIN_STP;
  end

  always_comb begin
    offset_d  = offset_q;
    gain_d    = gain_q;
    // Flags clear on a commit, but a pulse landing in the commit cycle is
    // still captured for the following boundary.
    pend_bi_d = (frame_en_i ? 1'b0 : pend_bi_q) | capBi;
    pend_bd_d = (frame_en_i ? 1'b0 : pend_bd_q) | capBd;
    pend_ci_d = (frame_en_i ? 1'b0 : pend_ci_q) | capCi;
    pend_cd_d = (frame_en_i ? 1'b0 : pend_cd_q) | capCd;

    if (frame_en_i) begin
      if (pend_bi_q && !pend_bd_q) begin
        offset_d = (offUp > OFF_MAX) ? OFF_MAX[8:0] : offUp[8:0];
      end else if (pend_bd_q && !pend_bi_q) begin
        offset_d = (offDn < OFF_MIN) ? OFF_MIN[8:0] : offDn[8:0];
      end

      if (pend_ci_q && !pend_cd_q) begin
        gain_d = (gainUp > GAIN_HI) ? GAIN_HI[7:0] : gainUp[7:0];
      end else if (pend_cd_q && !pend_ci_q) begin
        gain_d = gainDn[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q  <= '0;
      gain_q    <= 8'(G_RESET);
      pend_bi_q <= 1'b0;
      pend_bd_q <= 1'b0;
      pend_ci_q <= 1'b0;
      pend_cd_q <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      gain_q    <= gain_d;
      pend_bi_q <= pend_bi_d;
      pend_bd_q <= pend_bd_d;
      pend_ci_q <= pend_ci_d;
      pend_cd_q <= pend_cd_d;
    end
  end

  assign offset_out_o = offset_q;
  assign gain_out_o   = gain_q;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------
  // Signed 9-bit difference times the unsigned gain. Operands are widened to
  // 17 bits first so the product is formed at its final width.
  function automatic logic [16:0] mulGain(input logic [8:0] diff,
                                          input logic [7:0] gain);
    logic signed [16:0] prod;
    prod = $signed({{8{diff[8]}}, diff}) * $signed({9'b0, gain});
    return prod;
  endfunction

  // Drop the Q4.4 fraction (floor), re-centre on 128, add the offset, and
  // saturate to 0..255.
  function automatic logic [7:0] finishChannel(input logic [16:0] prod,
                                               input logic [8:0]  off);
    logic signed [16:0] shifted;
    logic [17:0]        sum;
    shifted = $signed(prod) >>> 4;
    sum     = {shifted[16], shifted} + 18'd128 + {{9{off[8]}}, off};
    if (sum[17]) begin
      return 8'd0;
    end else if (|sum[16:8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

  // ---------------------------------------------------------------------
  // S1: centre each channel and snapshot the settings
  // ---------------------------------------------------------------------
  // Offset and gain are captured with the pixel, so a commit that lands
  // while the pixel is in flight cannot give it a mixed pair.
  logic [2:0][8:0] s1Diff_q;
  logic [8:0]      s1Off_q;
  logic [7:0]      s1Gain_q;
  logic            s1En_q;
  logic [23:0]     s1Pix_q;
  logic            s1Valid_q;
  logic [2:0]      s1Sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Diff_q  <= '0;
      s1Off_q   <= '0;
      s1Gain_q  <= '0;
      s1En_q    <= 1'b0;
      s1Pix_q   <= '0;
      s1Valid_q <= 1'b0;
      s1Sync_q  <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s1Diff_q[c] <= {1'b0, pix_in_i[c*8 +: 8]} - 9'd128;
      end
      s1Off_q   <= offset_q;
      s1Gain_q  <= gain_q;
      s1En_q    <= en_bc_i;
      s1Pix_q   <= pix_in_i;
      s1Valid_q <= valid_in_i;
      s1Sync_q  <= sync_in_i;
    end
  end

  // ---------------------------------------------------------------------
  // S2: multiply by gain
  // ---------------------------------------------------------------------
  logic [2:0][16:0] s2Prod_q;
  logic [8:0]       s2Off_q;
  logic             s2En_q;
  logic [23:0]      s2Pix_q;
  logic             s2Valid_q;
  logic [2:0]       s2Sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Prod_q  <= '0;
      s2Off_q   <= '0;
      s2En_q    <= 1'b0;
      s2Pix_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Sync_q  <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s2Prod_q[c] <= mulGain(s1Diff_q[c], s1Gain_q);
      end
      s2Off_q   <= s1Off_q;
      s2En_q    <= s1En_q;
      s2Pix_q   <= s1Pix_q;
      s2Valid_q <= s1Valid_q;
      s2Sync_q  <= s1Sync_q;
    end
  end

  // ---------------------------------------------------------------------
  // S3: shift, add offset, saturate (or pass raw pixel when disabled)
  // ---------------------------------------------------------------------
  logic [23:0] pixAdj;

  always_comb begin
    pixAdj = '0;
    for (int c = 0; c < 3; c++) begin
      pixAdj[c*8 +: 8] = finishChannel(s2Prod_q[c], s2Off_q);
    end
  end

  logic [23:0] pixOut_q;
  logic        validOut_q;
  logic [2:0]  syncOut_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixOut_q   <= '0;
      validOut_q <= 1'b0;
      syncOut_q  <= '0;
    end else begin
      pixOut_q   <= s2En_q ? pixAdj : s2Pix_q;
      validOut_q <= s2Valid_q;
      syncOut_q  <= s2Sync_q;
    end
  end

  assign pix_out_o   = pixOut_q;
  assign valid_out_o = validOut_q;
  assign sync_out_o  = syncOut_q;

endmodule

// File: doc/bc_adjust.md
Name: bc_adjust

Overview:
- Per-pixel brightness/contrast processing stage that sits directly downstream of the control block.
- Consumes the control block's single-cycle adjust pulses (binc/bdec/cinc/cdec), its frame_en strobe and its brightness-enable bit (en[0]).
- Keeps a signed brightness offset and a contrast gain, and commits pending changes only at frame boundaries so no frame tears.
- Applies out = clamp(((p-128)*gain >>> 4) + 128 + offset) to each 8-bit RGB channel through a 3-stage pipeline.

Parameters:
- B_STEP, 8, brightness offset change per committed step.
- B_LIMIT, 128, offset saturates to the range -B_LIMIT..+B_LIMIT.
- G_RESET, 16, gain reset value (Q4.4, so 16 = 1.0).
- G_STEP, 2, gain change per committed step (2 = 0.125).
- G_MIN, 4, minimum gain (0.25).
- G_MAX, 64, maximum gain (4.0).

Ports:
- clk  in  1  pixel clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en_bc  in  1  brightness/contrast enable (control en[0]).
- frame_en  in  1  one-cycle frame-boundary strobe.
- binc  in  1  brightness increase pulse.
- bdec  in  1  brightness decrease pulse.
- cinc  in  1  contrast increase pulse.
- cdec  in  1  contrast decrease pulse.
- pix_in  in  24  {R,G,B} 8 bits each.
- valid_in  in  1  pix_in qualifier.
- sync_in  in  3  {vs,hs,de} sideband.
- pix_out  out  24  adjusted pixel.
- valid_out  out  1  valid_in delayed 3 cycles.
- sync_out  out  3  sync_in delayed 3 cycles.
- offset_out  out  9  active offset, signed two's complement.
- gain_out  out  8  active gain, Q4.4.

Behaviour:
- Reset (async, rst=1):
  - offset=0, gain=G_RESET, all pending flags=0.
  - All pipeline registers=0, so pix_out=0, valid_out=0, sync_out=0.
  - Asserting rst mid-frame discards in-flight pixels and pending steps immediately.
- Pending capture (only while en_bc=1; pulses are ignored when en_bc=0):
  - binc sets pend_bi; bdec sets pend_bd; cinc sets pend_ci; cdec sets pend_cd.
  - Flags are sticky: repeated pulses in one frame still yield one step.
  - binc and bdec asserted in the same cycle: both ignored. Same rule for cinc and cdec.
  - A pulse arriving in the same cycle as frame_en is captured for the next boundary, not the current one.
- Commit (cycle where frame_en=1):
  - pend_bi & !pend_bd: offset = min(offset+B_STEP, B_LIMIT).
  - pend_bd & !pend_bi: offset = max(offset-B_STEP, -B_LIMIT).
  - Both flags set: no change.
  - Gain follows the same rules, clamped to G_MIN..G_MAX.
  - All four flags clear in the commit cycle, then the same-cycle captures described above apply.
  - Commit happens regardless of en_bc, so any pending steps are flushed.
- Pipeline (advances every cycle, no stall; latency exactly 3 cycles):
  - S1: d = {1'b0,p} - 128, 9-bit signed per channel. Snapshot offset and gain into S1 so each pixel uses one coherent pair even when a commit lands mid-flight. Also register en_bc, the raw pixel, valid and sync.
  - S2: m = d * gain, 17-bit signed.
  - S3: r = (m >>> 4) + 128 + offset. Arithmetic shift floors toward -inf. Compute at 18-bit signed. Saturate below 0 to 0 and above 255 to 255.
  - If the snapshotted en_bc=0, S3 outputs the raw pixel unchanged (pass-through at the same 3-cycle latency).
- valid_in=0: data still flows and sync is still delayed; pix_out is don't-care when valid_out=0.
- offset_out and gain_out reflect the committed registers, updated one cycle after frame_en.

Test Plan:
- Reset → pix_out=0, valid_out=0, offset_out=0, gain_out=16. Then stream pixel 0x64C8FF with en_bc=1 → 0x64C8FF appears 3 cycles after valid_in.
- binc pulse, then frame_en → offset_out=8. Pixel R=100 → 108; R=250 → 255. 20 more binc+frame_en pairs → offset_out holds 128.
- Four cinc+frame_en pairs → gain_out=24. One more pair → gain_out=26. With gain=32, pixel R=100 → 72, R=200 → 255, R=128 → 128.
- binc and bdec in one cycle, then frame_en → offset unchanged. bdec in the same cycle as frame_en → no change that frame, offset -8 at the next frame_en.
- en_bc=0 with offset=40 → pixels pass through unchanged, and a binc pulse is ignored at frame_en. Reassert en_bc → offset 40 applies again.
- rst asserted mid-stream with 3 pixels in flight → valid_out=0 during rst, and offset/gain return to 0/16 asynchronously.
